// File: rtl/irq_nest_ctrl.sv
// rtl/irq_nest_ctrl.sv - nested interrupt sequencer between HETIC arbiter and core
module irq_nest_ctrl #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int StackDepth = 8,
  localparam int IrqWidth   = $clog2(NrIrqLines),
  localparam int PrioWidth  = $clog2(NrIrqPrios),
  localparam int DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
  output logic                  irq_ack_o,
  output logic [IrqWidth-1:0]   irq_id_o,
  output logic                  core_irq_o,
  output logic [IrqWidth-1:0]   core_irq_id_o,
  output logic [PrioWidth-1:0]  core_irq_level_o,
  output logic                  core_irq_heti_o,
  input  logic                  core_irq_ack_i,
  input  logic                  core_mret_i,
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  underflow_o
);

  localparam int IdxWidth = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  typedef enum logic [1:0] {IDLE, REQ, CLAIM} state_t;

  state_t                state_q, state_d;
  logic [PrioWidth-1:0]  lvl_q [StackDepth];
  logic                  nest_q [StackDepth];
  logic [DepthWidth-1:0] depth_q;
  logic [IrqWidth-1:0]   id_q;
  logic [PrioWidth-1:0]  level_q;
  logic                  heti_q;
  logic                  nest_lat_q;
  logic                  ack_q;
  logic                  underflow_q;

  logic                  stack_empty, stack_full, top_nest, eligible;
  logic                  pop, push, latch;
  logic [PrioWidth-1:0]  top_level;
  logic [IdxWidth-1:0]   top_idx, push_idx;
  logic [DepthWidth-1:0] depth_popped;

  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DepthWidth'(StackDepth));
  assign top_idx     = IdxWidth'(depth_q - 1'b1);
  assign top_level   = stack_empty ? '0 : lvl_q[top_idx];
  assign top_nest    = nest_q[top_idx];

  // A non-nestable handler on top blocks every line, whatever its level.
  assign eligible = irq_valid_i && (irq_level_i > top_level) && !stack_full &&
                    (stack_empty || top_nest);

  // Pop happens before push, so a simultaneous take replaces the top entry.
  assign pop          = core_mret_i && !stack_empty;
  assign depth_popped = pop ? depth_q - 1'b1 : depth_q;
  assign push_idx     = IdxWidth'(depth_popped);

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          latch   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (core_irq_ack_i) begin
          push    = 1'b1;
          state_d = CLAIM;
        end else if (!irq_valid_i || (irq_id_i != id_q)) begin
          state_d = IDLE;
        end
      end
      CLAIM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      id_q        <= '0;
      level_q     <= '0;
      heti_q      <= 1'b0;
      nest_lat_q  <= 1'b0;
      ack_q       <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < StackDepth; i++) begin
        lvl_q[i]  <= '0;
        nest_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == CLAIM);
      if (latch) begin
        id_q       <= irq_id_i;
        level_q    <= irq_level_i;
        heti_q     <= irq_heti_i;
        nest_lat_q <= irq_nest_i;
      end
      if (core_mret_i && stack_empty) begin
        underflow_q <= 1'b1;
      end
      depth_q <= push ? depth_popped + 1'b1 : depth_popped;
      if (push) begin
        lvl_q[push_idx]  <= level_q;
        nest_q[push_idx] <= nest_lat_q;
      end
    end
  end

  assign irq_ack_o        = ack_q;
  assign irq_id_o         = id_q;
  assign core_irq_o       = (state_q == REQ);
  assign core_irq_id_o    = id_q;
  assign core_irq_level_o = level_q;
  assign core_irq_heti_o  = heti_q;
  assign cur_level_o      = top_level;
  assign depth_o          = depth_q;
  assign underflow_o      = underflow_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb/tb_irq_nest_ctrl.sv - scoreboard bench for irq_nest_ctrl with queue-based stack model
module tb_irq_nest_ctrl;

  localparam int IW = 6;
  localparam int PW = 5;
  localparam int DW = 4;
  localparam int SD = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          irq_valid_i;
  logic [IW-1:0] irq_id_i;
  logic [PW-1:0] irq_level_i;
  logic          irq_heti_i;
  logic          irq_nest_i;
  logic          irq_ack_o;
  logic [IW-1:0] irq_id_o;
  logic          core_irq_o;
  logic [IW-1:0] core_irq_id_o;
  logic [PW-1:0] core_irq_level_o;
  logic          core_irq_heti_o;
  logic          core_irq_ack_i;
  logic          core_mret_i;
  logic [PW-1:0] cur_level_o;
  logic [DW-1:0] depth_o;
  logic          underflow_o;

  irq_nest_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .irq_valid_i      (irq_valid_i),
    .irq_id_i         (irq_id_i),
    .irq_level_i      (irq_level_i),
    .irq_heti_i       (irq_heti_i),
    .irq_nest_i       (irq_nest_i),
    .irq_ack_o        (irq_ack_o),
    .irq_id_o         (irq_id_o),
    .core_irq_o       (core_irq_o),
    .core_irq_id_o    (core_irq_id_o),
    .core_irq_level_o (core_irq_level_o),
    .core_irq_heti_o  (core_irq_heti_o),
    .core_irq_ack_i   (core_irq_ack_i),
    .core_mret_i      (core_mret_i),
    .cur_level_o      (cur_level_o),
    .depth_o          (depth_o),
    .underflow_o      (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [PW-1:0] lvl;
    logic          nest;
  } ent_t;

  typedef struct packed {
    logic          req;
    logic [IW-1:0] id;
    logic [PW-1:0] lvl;
    logic          heti;
    logic          ack;
    logic [PW-1:0] cur;
    logic [DW-1:0] depth;
    logic          uf;
  } exp_t;

  ent_t          stk[$];
  exp_t          exp_q[$];
  logic [IW-1:0] claim_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  // Reference model: an interrupt is offered, then taken, then claimed.
  bit            m_req, m_claim, m_heti, m_nest, m_uf;
  logic [IW-1:0] m_id;
  logic [PW-1:0] m_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [IW-1:0] id, input logic [PW-1:0] lvl,
                      input bit h, input bit n, input bit ack, input bit mret);
    logic [PW-1:0] cur;
    bit            elig;
    exp_t          e;
    rst_i          = r;
    irq_valid_i    = v;
    irq_id_i       = id;
    irq_level_i    = lvl;
    irq_heti_i     = h;
    irq_nest_i     = n;
    core_irq_ack_i = ack && m_req;
    core_mret_i    = mret;
    if (r) begin
      if (m_claim) void'(claim_q.pop_back());
      stk.delete();
      m_req = 0; m_claim = 0; m_heti = 0; m_nest = 0; m_uf = 0; m_id = '0; m_lvl = '0;
    end else begin
      cur  = 0;
      elig = v && (stk.size() < SD);
      if (stk.size() > 0) begin
        cur  = stk[stk.size()-1].lvl;
        elig = elig && stk[stk.size()-1].nest;
      end
      elig = elig && (lvl > cur);
      if (mret) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_uf = 1;
      end
      if (m_claim) begin
        m_claim = 0;
      end else if (m_req) begin
        if (ack) begin
          stk.push_back('{lvl: m_lvl, nest: m_nest});
          m_req   = 0;
          m_claim = 1;
          claim_q.push_back(m_id);
        end else if (!v || id != m_id) begin
          m_req = 0;
        end
      end else if (elig) begin
        m_req = 1; m_id = id; m_lvl = lvl; m_heti = h; m_nest = n;
      end
    end
    e.req   = m_req;
    e.id    = m_id;
    e.lvl   = m_lvl;
    e.heti  = m_heti;
    e.ack   = m_claim;
    e.cur   = (stk.size() > 0) ? stk[stk.size()-1].lvl : '0;
    e.depth = DW'(stk.size());
    e.uf    = m_uf;
    exp_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_irq", 32'(core_irq_o), 32'(e.req));
        chk("core_irq_id", 32'(core_irq_id_o), 32'(e.id));
        chk("core_irq_level", 32'(core_irq_level_o), 32'(e.lvl));
        chk("core_irq_heti", 32'(core_irq_heti_o), 32'(e.heti));
        chk("irq_ack", 32'(irq_ack_o), 32'(e.ack));
        chk("irq_id", 32'(irq_id_o), 32'(e.id));
        chk("cur_level", 32'(cur_level_o), 32'(e.cur));
        chk("depth", 32'(depth_o), 32'(e.depth));
        chk("underflow", 32'(underflow_o), 32'(e.uf));
      end
      if (irq_ack_o === 1'b1) begin
        if (claim_q.size() == 0) begin
          chk("claim_unexpected", 32'(irq_id_o), 32'hFFFF_FFFF);
        end else begin
          chk("claim_id", 32'(irq_id_o), 32'(claim_q.pop_front()));
        end
      end
    end
  end

  initial begin : stim
    logic          rv, rh, rn;
    logic [IW-1:0] rid;
    logic [PW-1:0] rl;
    rst_i = 1; irq_valid_i = 0; irq_id_i = 0; irq_level_i = 0; irq_heti_i = 0;
    irq_nest_i = 0; core_irq_ack_i = 0; core_mret_i = 0;
    @(negedge clk_i);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // basic take and claim
    step(0, 1, 5, 3, 1, 1, 0, 0);
    step(0, 1, 5, 3, 1, 1, 1, 0);
    idle(2);
    // preemption, lower level ignored, return
    step(0, 1, 9, 7, 0, 1, 0, 0);
    step(0, 1, 9, 7, 0, 1, 1, 0);
    idle(1);
    repeat (3) step(0, 1, 2, 5, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // non-nestable top blocks until its mret
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 4, 3, 0, 0, 0, 0);
    step(0, 1, 4, 3, 0, 0, 1, 0);
    idle(1);
    repeat (3) step(0, 1, 9, 7, 0, 1, 0, 0);
    step(0, 1, 9, 7, 0, 1, 0, 1);
    repeat (2) step(0, 1, 9, 7, 0, 1, 0, 0);
    step(0, 1, 9, 7, 0, 1, 1, 0);
    idle(2);
    // withdraw on new winner and on valid drop
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 3, 0, 1, 0, 0);
    step(0, 1, 6, 3, 0, 1, 0, 0);
    step(0, 1, 6, 3, 0, 1, 0, 0);
    step(0, 0, 6, 3, 0, 1, 0, 0);
    idle(2);
    // fill, then full, then drain into underflow
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < SD; k++) begin
      step(0, 1, IW'(k), PW'(k + 1), 0, 1, 0, 0);
      step(0, 1, IW'(k), PW'(k + 1), 0, 1, 1, 0);
      idle(1);
    end
    repeat (3) step(0, 1, 20, 31, 0, 1, 1, 0);
    repeat (SD + 1) step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // simultaneous take and return, then reset during claim
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0, 1, 0, 0);
    step(0, 1, 1, 2, 0, 1, 1, 0);
    idle(1);
    step(0, 1, 2, 4, 1, 1, 0, 0);
    step(0, 1, 2, 4, 1, 1, 1, 0);
    idle(1);
    step(0, 1, 7, 20, 0, 1, 0, 0);
    step(0, 1, 7, 20, 0, 1, 1, 1);
    idle(1);
    step(0, 1, 8, 25, 1, 1, 0, 0);
    step(0, 1, 8, 25, 1, 1, 1, 0);
    step(1, 1, 8, 25, 1, 1, 0, 0);
    idle(2);
    // randomized traffic with persistent arbiter outputs
    rv = 0; rh = 0; rn = 1; rid = 0; rl = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 30) begin
        rv  = ($urandom_range(99) < 70);
        rid = IW'($urandom_range(7));
        rl  = PW'($urandom_range(31));
        rh  = 1'($urandom);
        rn  = ($urandom_range(99) < 80);
      end
      step($urandom_range(999) < 3, rv, rid, rl, rh, rn,
           $urandom_range(99) < 50, $urandom_range(99) < 12);
    end
    idle(3);
    @(posedge clk_i);
    #2;
    chk("claims_outstanding", 32'(claim_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
